// File: rtl/registers_param.sv
// registers_param: parametrised 2R/1W register file with clear sequencer, zero register and write bypass
module registers_param #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [WIDTH-1:0]  writeData,
  input  logic              regWrite,
  output logic [WIDTH-1:0]  regA,
  output logic [WIDTH-1:0]  regB,
  output logic              ready,
  output logic              wr_drop
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              ready_q, ready_d, wr_drop_q, wr_drop_d, last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [WIDTH-1:0]  mem_wd;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  function automatic logic [WIDTH-1:0] rd(input logic [ADDR_W-1:0] a);
    return !ready_q ? '0 :
           (ZERO_REG != 0 && a == '0) ? '0 :
           (BYPASS != 0 && regWrite && a == writeReg) ? writeData : mem_q[a];
  endfunction
  always_comb begin
    last      = state_q == CLEAR && &clr_ptr_q;
    state_d   = rst ? CLEAR : last ? RUN : state_q;
    clr_ptr_d = (rst || state_q == RUN) ? '0 : clr_ptr_q + ADDR_W'(1);
    ready_d   = !rst && (ready_q || last);
    wr_drop_d = !rst && (wr_drop_q || (regWrite && !ready_q));
    mem_we    = !rst && (state_q == CLEAR || (regWrite && !(ZERO_REG != 0 && writeReg == '0)));
    mem_wa    = state_q == CLEAR ? clr_ptr_q : writeReg;
    mem_wd    = state_q == CLEAR ? '0 : writeData;
    regA      = rd(readReg1);
    regB      = rd(readReg2);
    ready     = ready_q;
    wr_drop   = wr_drop_q;
  end
  always_ff @(posedge clk) begin
    state_q   <= state_d;
    clr_ptr_q <= clr_ptr_d;
    ready_q   <= ready_d;
    wr_drop_q <= wr_drop_d;
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end
endmodule

// File: tb/tb_registers_param.sv
// tb_registers_param: table and scoreboard bench for registers_param in three configurations
module tb_registers_param;
  logic        clk = 0;
  logic        rst = 1, rst_c = 1, we = 0;
  logic [4:0]  rr1 = 0, rr2 = 0, wr = 0;
  logic [31:0] wd = 0;
  logic [31:0] a_a, a_b, b_a, b_b;
  logic [15:0] c_a, c_b;
  logic        a_rdy, a_drop, b_rdy, b_drop, c_rdy, c_drop;
  int          n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  registers_param dut_a (
    .clk(clk), .rst(rst), .readReg1(rr1), .readReg2(rr2), .writeReg(wr), .writeData(wd),
    .regWrite(we), .regA(a_a), .regB(a_b), .ready(a_rdy), .wr_drop(a_drop)
  );
  registers_param #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .readReg1(rr1), .readReg2(rr2), .writeReg(wr), .writeData(wd),
    .regWrite(we), .regA(b_a), .regB(b_b), .ready(b_rdy), .wr_drop(b_drop)
  );
  registers_param #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut_c (
    .clk(clk), .rst(rst_c), .readReg1(rr1[2:0]), .readReg2(rr2[2:0]), .writeReg(wr[2:0]),
    .writeData(wd[15:0]), .regWrite(we), .regA(c_a), .regB(c_b), .ready(c_rdy), .wr_drop(c_drop)
  );
  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];
  typedef struct {
    logic [4:0]  r1, r2, w;
    logic [31:0] d;
    logic        e;
    logic [31:0] a, b, ba, bb;
  } vec_t;
  vec_t tbl[11];
  function automatic logic [31:0] act_of(input int s);
    case (s)
      0:  return a_a;
      1:  return a_b;
      2:  return {31'd0, a_rdy};
      3:  return {31'd0, a_drop};
      4:  return b_a;
      5:  return b_b;
      6:  return {31'd0, b_rdy};
      7:  return {31'd0, b_drop};
      8:  return {16'd0, c_a};
      9:  return {16'd0, c_b};
      10: return {31'd0, c_rdy};
      default: return {31'd0, c_drop};
    endcase
  endfunction
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = sb.pop_front();
      act = act_of(e.sig);
      n_chk++;
      if (act === e.exp) n_pass++;
      else $display("FAIL %s: got %h want %h at %0t", e.name, act, e.exp, $time);
    end
  end
  task automatic push(input string name, input int sig, input logic [31:0] exp);
    sb.push_back('{name, sig, exp});
  endtask
  task automatic cyc(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] w,
                     input logic [31:0] d, input logic e);
    @(posedge clk);
    #1;
    rr1 = r1;
    rr2 = r2;
    wr = w;
    wd = d;
    we = e;
  endtask
  task automatic pulse_and_clear(input int inj);
    @(posedge clk);
    #1;
    rst = 1;
    we = 0;
    rr1 = 7;
    @(posedge clk);
    #1;
    rst = 0;
    push("rst_ready", 2, 0);
    push("rst_drop", 3, 0);
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      #1;
      we = (k == inj);
      wr = 3;
      wd = 32'h55;
      push("clr_ready", 2, {31'd0, k == 32});
      push("clr_regA", 0, 0);
      push("clr_drop", 3, {31'd0, inj >= 0 && k > inj});
      if (k == 32) push("clr_ready_b", 6, 1);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end
  initial begin
    tbl[0]  = '{5'd5,  5'd5,  5'd5,  32'h12345678, 1'b1, 32'h12345678, 32'h12345678, 32'h0, 32'h0};
    tbl[1]  = '{5'd5,  5'd5,  5'd5,  32'hFFFFFFFF, 1'b0, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
    tbl[2]  = '{5'd5,  5'd0,  5'd0,  32'h0,        1'b0, 32'h12345678, 32'h0, 32'h12345678, 32'h0};
    tbl[3]  = '{5'd0,  5'd1,  5'd0,  32'hAAAA5555, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[4]  = '{5'd0,  5'd0,  5'd0,  32'h0,        1'b0, 32'h0, 32'h0, 32'hAAAA5555, 32'hAAAA5555};
    tbl[5]  = '{5'd9,  5'd9,  5'd9,  32'h1,        1'b1, 32'h1, 32'h1, 32'h0, 32'h0};
    tbl[6]  = '{5'd9,  5'd9,  5'd9,  32'h2,        1'b1, 32'h2, 32'h2, 32'h1, 32'h1};
    tbl[7]  = '{5'd9,  5'd9,  5'd0,  32'h0,        1'b0, 32'h2, 32'h2, 32'h2, 32'h2};
    tbl[8]  = '{5'd9,  5'd5,  5'd5,  32'h77,       1'b1, 32'h2, 32'h77, 32'h2, 32'h12345678};
    tbl[9]  = '{5'd5,  5'd9,  5'd31, 32'hCAFEF00D, 1'b1, 32'h77, 32'h2, 32'h77, 32'h2};
    tbl[10] = '{5'd31, 5'd31, 5'd0,  32'h0,        1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D};
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    push("init_ready", 2, 0);
    push("init_drop", 3, 0);
    push("init_regA", 0, 0);
    rst_c = 0;
    pulse_and_clear(-1);
    cyc(7, 0, 7, 32'hDEADBEEF, 1);
    push("preload_bypass_a", 0, 32'hDEADBEEF);
    push("preload_nobypass_b", 4, 0);
    cyc(7, 0, 0, 0, 0);
    push("preload_a", 0, 32'hDEADBEEF);
    push("preload_b", 4, 32'hDEADBEEF);
    pulse_and_clear(-1);
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].r1, tbl[i].r2, tbl[i].w, tbl[i].d, tbl[i].e);
      push($sformatf("vec%0d_a_regA", i), 0, tbl[i].a);
      push($sformatf("vec%0d_a_regB", i), 1, tbl[i].b);
      push($sformatf("vec%0d_b_regA", i), 4, tbl[i].ba);
      push($sformatf("vec%0d_b_regB", i), 5, tbl[i].bb);
    end
    push("run_drop", 3, 0);
    pulse_and_clear(2);
    cyc(3, 3, 0, 0, 0);
    push("drop_r3_a", 0, 0);
    push("drop_r3_b", 1, 0);
    push("drop_r3_zb", 4, 0);
    push("drop_sticky_b", 7, 1);
    cyc(7, 3, 0, 0, 0);
    push("c_pre_r7", 8, 32'hF00D);
    push("c_pre_r3", 9, 32'h0055);
    push("c_pre_ready", 10, 1);
    @(posedge clk);
    #1;
    rst_c = 1;
    @(posedge clk);
    #1;
    rst_c = 0;
    push("c_rst_ready", 10, 0);
    push("c_rst_drop", 11, 0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      push("c_clr1_ready", 10, 0);
      if (k == 3) rst_c = 1;
    end
    @(posedge clk);
    #1;
    rst_c = 0;
    push("c_rst2_ready", 10, 0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      push("c_clr2_ready", 10, {31'd0, k == 8});
    end
    for (int a = 0; a < 8; a++) begin
      cyc(5'(a), 5'(7 - a), 0, 0, 0);
      push($sformatf("c_zero_a%0d", a), 8, 0);
      push($sformatf("c_zero_b%0d", 7 - a), 9, 0);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (c_a === 16'h0) n_pass++;
    else $display("FAIL end_c_a: got %h want 0000", c_a);
    n_chk++;
    if (c_rdy === 1'b1) n_pass++;
    else $display("FAIL end_c_ready: got %b want 1", c_rdy);
    n_chk++;
    if (a_drop === 1'b1) n_pass++;
    else $display("FAIL end_a_drop: got %b want 1", a_drop);
    n_chk++;
    if (b_drop === 1'b1) n_pass++;
    else $display("FAIL end_b_drop: got %b want 1", b_drop);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/registers_param.md
Name: registers_param

Overview:
- Parametrised successor to the two-read/one-write general-purpose register file in the CPMath datapath.
- Adds configurable data width and depth, an honoured write-enable, an optional hardwired-zero register 0, and optional write-to-read bypass.
- A synchronous reset starts a clear sequencer that zeroes every entry, one per cycle, and raises a ready flag when done.
- Sits between the decode stage (read addresses) and the writeback stage (write port).

Parameters:
- WIDTH, 32, data width of each register in bits.
- ADDR_W, 5, address width; depth is DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes; when 0 it is a normal register.
- BYPASS, 1, when 1 a same-cycle write is forwarded to a matching read port; when 0 reads return the stored value only.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- readReg1  input  ADDR_W  read address, port A.
- readReg2  input  ADDR_W  read address, port B.
- writeReg  input  ADDR_W  write address.
- writeData  input  WIDTH  write data.
- regWrite  input  1  write enable.
- regA  output  WIDTH  read data, port A (combinational).
- regB  output  WIDTH  read data, port B (combinational).
- ready  output  1  high once the clear sequence has finished; writes are accepted only while high.
- wr_drop  output  1  sticky flag set when regWrite=1 arrives while ready=0; cleared only by rst.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- State machine, states CLEAR and RUN:
  - rst=1 at a clock edge: state<=CLEAR, clr_ptr<=0, ready<=0, wr_drop<=0. This applies from any state, including mid-clear, which restarts at entry 0.
  - CLEAR, each cycle with rst=0: mem[clr_ptr]<=0 and clr_ptr<=clr_ptr+1.
  - CLEAR with clr_ptr==DEPTH-1: that entry is zeroed, state<=RUN and ready<=1 on the same edge.
  - The clear therefore takes exactly DEPTH cycles after rst deasserts. ready first reads 1 on the DEPTH-th edge after the last rst=1 edge.
- Reset values: ready=0, wr_drop=0; regA and regB read 0 throughout CLEAR.
- Writes:
  - In RUN, with regWrite=1, mem[writeReg]<=writeData at the rising edge.
  - With ZERO_REG=1, a write to address 0 is discarded silently and does not set wr_drop.
  - regWrite=0 never writes, whatever writeReg holds.
  - regWrite=1 in CLEAR is dropped (the clear value wins) and sets wr_drop<=1.
- Reads:
  - Combinational, zero latency.
  - Priority, highest first:
    1. ready=0 gives 0.
    2. ZERO_REG=1 and address 0 gives 0.
    3. BYPASS=1, regWrite=1 and the read address equals writeReg gives writeData.
    4. Otherwise mem[addr].
  - Both ports may read the same address, and both may match the write address, in the same cycle.
- Width and wrap:
  - clr_ptr is ADDR_W+1 bits or compares against DEPTH-1 before incrementing; it never wraps to re-clear while in RUN.
  - Addresses are full-range; no out-of-range case exists.
- Simultaneous rst=1 and regWrite=1: rst wins, no write, wr_drop stays 0.

Test Plan:
1. Reset clear: pre-load mem[7]=0xDEADBEEF, pulse rst for 1 cycle -> ready=0 for exactly 32 edges, then 1; regA with readReg1=7 reads 0 after ready.
2. Write/read: in RUN, write 0x12345678 to r5 with regWrite=1; next cycle readReg1=5, readReg2=5 -> regA=regB=0x12345678. A cycle with regWrite=0, writeReg=5, writeData=0xFFFFFFFF leaves r5 unchanged.
3. Zero register: write 0xAAAA5555 to r0 with regWrite=1 -> regA reads 0 in the same cycle (no bypass) and later. With ZERO_REG=0 the same write reads back 0xAAAA5555.
4. Bypass: r9 holds 0x1; in the same cycle regWrite=1, writeReg=9, writeData=0x2, readReg2=9 -> regB=0x2 combinationally. With BYPASS=0, regB=0x1 that cycle and 0x2 the next.
5. Write during clear: after rst, assert regWrite=1 to r3 with 0x55 on clear cycle 2 -> wr_drop=1 and stays 1; after ready, r3 reads 0.
6. Mid-clear reset, with WIDTH=16 and ADDR_W=3: assert rst on clear cycle 4 -> ready rises exactly 8 edges after the second rst; all 8 entries read 0x0000.
